multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//   Central FSM for the multicycle core. Steps each instruction through
//   FETCH, DECODE, EXEC, MEM and WB, and drives the enables for IR, decode
//   latch, ALU stage, register file and PC. Owns the shared memory port
//   handshake for instruction and data accesses, and counts retired instructions.
// PARAMETERS
//   OPC_W     6          opcode width (instr[31:26])
//   HALT_OPC  6'b111111  opcode that stops the core
//   CNT_W     32         width of retired-instruction counter
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   rst          in   1      synchronous reset, active-high
//   start        in   1      pulse: leave IDLE and begin fetching
//   opcode       in   OPC_W  opcode of the latched IR
//   ctrl_mem_rd  in   1      decoded: instruction loads from memory
//   ctrl_mem_wr  in   1      decoded: instruction stores to memory
//   ctrl_reg_wr  in   1      decoded: instruction writes the register bank
//   ctrl_pc_jmp  in   1      decoded: take branch/jump target (new_pc)
//   mem_ack      in   1      memory completes current request this cycle
//   mem_req      out  1      memory request valid
//   mem_we       out  1      1 = write, 0 = read
//   mem_sel      out  1      0 = instruction address (PC), 1 = data address
//   ir_we        out  1      load IR from memory read data
//   id_en        out  1      enable decode-stage output registers
//   ex_en        out  1      enable ALU-stage registers
//   reg_we       out  1      register bank write enable
//   pc_we        out  1      update PC (retire strobe)
//   pc_src       out  1      0 = PC+4, 1 = new_pc
//   busy         out  1      state not IDLE and not HALT
//   halted       out  1      state == HALT
//   retired      out  CNT_W  retired-instruction count
//   state        out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
// BEHAVIOUR
//   - Reset: state=IDLE, retired=0. All outputs 0 from the first cycle after reset.
//     rst overrides every transition, including an ack in the same cycle.
//   - Outputs are combinational decodes of the registered state. ir_we and
//     pc_we also depend on mem_ack and the ctrl_* inputs.
//   - IDLE: start=1 -> FETCH. start is ignored in every other state.
//   - FETCH: mem_req=1, mem_sel=0, mem_we=0. Hold while mem_ack=0.
//     When mem_ack=1: ir_we=1 in that cycle, next state DECODE.
//   - DECODE: id_en=1 for exactly one cycle.
//     If opcode==HALT_OPC -> HALT, else -> EXEC.
//   - EXEC: ex_en=1 for one cycle.
//     If ctrl_mem_rd|ctrl_mem_wr -> MEM.
//     Else if ctrl_reg_wr -> WB.
//     Else retire -> FETCH.
//   - MEM: mem_req=1, mem_sel=1, mem_we=ctrl_mem_wr. Hold until mem_ack=1.
//     When mem_ack=1: if ctrl_mem_rd & !ctrl_mem_wr & ctrl_reg_wr -> WB,
//     else retire -> FETCH.
//   - WB: reg_we=1 for one cycle, then retire -> FETCH.
//   - Retire (the cycle leaving EXEC/MEM/WB for FETCH):
//     pc_we=1, pc_src=ctrl_pc_jmp, retired += 1.
//     retired wraps from all-ones to 0.
//   - HALT: halted=1, all other outputs 0. Only rst exits HALT.
//   - ctrl_* and opcode must be stable from DECODE until retire (IR is held).
//     They are sampled only in DECODE/EXEC/MEM/WB.
//   - mem_ack in IDLE/DECODE/EXEC/WB/HALT is ignored.
//   - ctrl_mem_rd & ctrl_mem_wr both 1: treated as a store (mem_we=1, no WB).
//   - Minimum latency per instruction with zero-wait memory:
//     ALU 4 cycles, jump 3, store 4, load 5.
// TESTING
//   1 ALU op (reg_wr=1), ack 2 cycles late in FETCH
//     -> FETCH x3, DECODE, EXEC, WB. reg_we 1 cycle, pc_we with pc_src=0, retired=1.
//   2 Load (rd=1, reg_wr=1), ack immediate
//     -> FETCH DECODE EXEC MEM WB. In MEM: mem_sel=1, mem_we=0. reg_we in WB. retired=1.
//   3 Store (wr=1), ack after 1 wait
//     -> MEM held 2 cycles with mem_we=1. No reg_we. Back to FETCH, pc_we=1.
//   4 Jump (pc_jmp=1, no mem, no reg_wr)
//     -> retire in EXEC cycle with pc_we=1, pc_src=1. 3 cycles total.
//   5 opcode=6'b111111 in DECODE -> HALT, halted=1, retired unchanged.
//     start pulse ignored. rst -> IDLE.
//   6 rst high in MEM with mem_ack=1 same cycle -> IDLE next, no retire, outputs 0.
//     CNT_W=4: 16 retires -> retired=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Central control FSM for the multicycle core: steps FETCH/DECODE/EXEC/MEM/WB,
// owns the shared memory handshake and counts retired instructions.
module multicycle_sequencer #(
    parameter int unsigned      OPC_W    = 6,
    parameter logic [OPC_W-1:0] HALT_OPC = '1,
    parameter int unsigned      CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             ctrl_mem_rd,
    input  logic             ctrl_mem_wr,
    input  logic             ctrl_reg_wr,
    input  logic             ctrl_pc_jmp,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_we,
    output logic             id_en,
    output logic             ex_en,
    output logic             reg_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             is_mem;
    logic             load_wb;

    assign is_mem  = ctrl_mem_rd | ctrl_mem_wr;
    // Read+write together behaves as a store, so only a pure load goes to WB.
    assign load_wb = ctrl_mem_rd & ~ctrl_mem_wr & ctrl_reg_wr;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_sel = 1'b0;
        ir_we   = 1'b0;
        id_en   = 1'b0;
        ex_en   = 1'b0;
        reg_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                id_en   = 1'b1;
                state_d = (opcode == HALT_OPC) ? StHalt : StExec;
            end
            StExec: begin
                ex_en = 1'b1;
                if (is_mem) begin
                    state_d = StMem;
                end else if (ctrl_reg_wr) begin
                    state_d = StWb;
                end else begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = ctrl_mem_wr;
                if (mem_ack) begin
                    if (load_wb) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign pc_we   = retire;
    assign pc_src  = retire & ctrl_pc_jmp;
    assign busy    = (state_q != StIdle) && (state_q != StHalt);
    assign halted  = (state_q == StHalt);
    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares whenever the core is active.
module tb_multicycle_sequencer;

    localparam int unsigned CNT_W = 4;

    // Flag order: req we sel ir_we id_en ex_en reg_we pc_we pc_src
    localparam logic [8:0] F_NONE  = 9'b000_000_000;
    localparam logic [8:0] F_FWAIT = 9'b100_000_000;
    localparam logic [8:0] F_FACK  = 9'b100_100_000;
    localparam logic [8:0] F_DEC   = 9'b000_010_000;
    localparam logic [8:0] F_EX    = 9'b000_001_000;
    localparam logic [8:0] F_EXJMP = 9'b000_001_011;
    localparam logic [8:0] F_WB    = 9'b000_000_110;
    localparam logic [8:0] F_MRD   = 9'b101_000_000;
    localparam logic [8:0] F_MWR   = 9'b111_000_000;
    localparam logic [8:0] F_MWRR  = 9'b111_000_010;
    localparam logic [8:0] F_MWRJ  = 9'b111_000_011;

    typedef struct packed {
        logic [2:0]       st;
        logic [8:0]       flags;
        logic             busy;
        logic             halted;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [5:0]       opcode;
    logic             ctrl_mem_rd, ctrl_mem_wr, ctrl_reg_wr, ctrl_pc_jmp;
    logic             mem_ack;
    logic             mem_req, mem_we, mem_sel, ir_we, id_en, ex_en, reg_we, pc_we, pc_src;
    logic             busy, halted;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] r;

    multicycle_sequencer #(
        .OPC_W   (6),
        .HALT_OPC(6'b111111),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .ctrl_mem_rd(ctrl_mem_rd),
        .ctrl_mem_wr(ctrl_mem_wr),
        .ctrl_reg_wr(ctrl_reg_wr),
        .ctrl_pc_jmp(ctrl_pc_jmp),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .ir_we      (ir_we),
        .id_en      (id_en),
        .ex_en      (ex_en),
        .reg_we     (reg_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .busy       (busy),
        .halted     (halted),
        .retired    (retired),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st, input logic [CNT_W-1:0] ret,
                                input logic [8:0] f);
        exp_t e;
        e.st     = st;
        e.flags  = f;
        e.busy   = (st != 3'd0) && (st != 3'd6);
        e.halted = (st == 3'd6);
        e.ret    = ret;
        return e;
    endfunction

    // One cycle: inputs already set by caller, expectation queued for the monitor.
    task automatic step(input logic ack, input exp_t e);
        mem_ack = ack;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic rd, input logic wr, input logic rw, input logic jmp);
        ctrl_mem_rd = rd;
        ctrl_mem_wr = wr;
        ctrl_reg_wr = rw;
        ctrl_pc_jmp = jmp;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t got, e;
        if (busy || halted || exp_q.size() != 0) begin
            got = {state, mem_req, mem_we, mem_sel, ir_we, id_en, ex_en, reg_we, pc_we,
                   pc_src, busy, halted, retired};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_activity got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL cycle_%0t got st=%0d f=%b b=%b h=%b ret=%0d required st=%0d f=%b b=%b h=%b ret=%0d",
                             $time, got.st, got.flags, got.busy, got.halted, got.ret,
                             e.st, e.flags, e.busy, e.halted, e.ret);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        opcode  = 6'd0;
        mem_ack = 1'b0;
        set_ctrl(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        r   = '0;

        // Reset state, then start
        step(0, mk(0, r, F_NONE));
        start = 1'b1;
        step(0, mk(0, r, F_NONE));
        start = 1'b0;

        // ALU op, ack two cycles late
        set_ctrl(0, 0, 1, 0);
        step(0, mk(1, r, F_FWAIT));
        step(0, mk(1, r, F_FWAIT));
        step(1, mk(1, r, F_FACK));
        step(0, mk(2, r, F_DEC));
        step(0, mk(3, r, F_EX));
        step(0, mk(5, r, F_WB));
        r++;

        // Load, zero-wait
        set_ctrl(1, 0, 1, 0);
        step(1, mk(1, r, F_FACK));
        step(0, mk(2, r, F_DEC));
        step(0, mk(3, r, F_EX));
        step(1, mk(4, r, F_MRD));
        step(0, mk(5, r, F_WB));
        r++;

        // Store, one wait in MEM
        set_ctrl(0, 1, 0, 0);
        step(1, mk(1, r, F_FACK));
        step(0, mk(2, r, F_DEC));
        step(0, mk(3, r, F_EX));
        step(0, mk(4, r, F_MWR));
        step(1, mk(4, r, F_MWRR));
        r++;

        // Jump, retires from EXEC
        set_ctrl(0, 0, 0, 1);
        step(1, mk(1, r, F_FACK));
        step(0, mk(2, r, F_DEC));
        step(0, mk(3, r, F_EXJMP));
        r++;

        // rd & wr & reg_wr & jmp: behaves as store, no WB
        set_ctrl(1, 1, 1, 1);
        step(1, mk(1, r, F_FACK));
        step(0, mk(2, r, F_DEC));
        step(0, mk(3, r, F_EX));
        step(1, mk(4, r, F_MWRJ));
        r++;

        // Reset in MEM with ack in same cycle
        set_ctrl(0, 1, 0, 0);
        step(1, mk(1, r, F_FACK));
        step(0, mk(2, r, F_DEC));
        step(0, mk(3, r, F_EX));
        rst = 1'b1;
        step(1, mk(4, r, F_MWRR));
        r = '0;
        step(0, mk(0, r, F_NONE));
        rst = 1'b0;
        step(0, mk(0, r, F_NONE));

        // Halt opcode; start ignored in HALT; only rst exits
        start = 1'b1;
        step(0, mk(0, r, F_NONE));
        start  = 1'b0;
        opcode = 6'b111111;
        set_ctrl(0, 0, 1, 0);
        step(1, mk(1, r, F_FACK));
        step(0, mk(2, r, F_DEC));
        step(1, mk(6, r, F_NONE));
        start = 1'b1;
        step(1, mk(6, r, F_NONE));
        start = 1'b0;
        step(0, mk(6, r, F_NONE));
        rst = 1'b1;
        step(0, mk(6, r, F_NONE));
        step(0, mk(0, r, F_NONE));
        rst = 1'b0;

        // 16 jumps wrap the 4-bit counter back to 0
        opcode = 6'd0;
        set_ctrl(0, 0, 0, 1);
        start = 1'b1;
        step(0, mk(0, r, F_NONE));
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1, mk(1, r, F_FACK));
            step(0, mk(2, r, F_DEC));
            step(0, mk(3, r, F_EXJMP));
            r++;
        end
        step(0, mk(1, 4'd0, F_FWAIT));
        rst = 1'b1;
        step(0, mk(1, 4'd0, F_FWAIT));
        step(0, mk(0, 4'd0, F_NONE));
        rst = 1'b0;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
